// File: rtl/change_dispenser.sv
`default_nettype none
// ============================================================================
//  Module      : change_dispenser
//  Description : Settles a coffee sale: compares paid against price, releases
//                a cup when funds suffice and pays the remainder back as
//                greedy coins through an ack handshake with a jam timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module change_dispenser #(
   parameter logic [3:0] COIN_HI     = 4'd5,
   parameter logic [3:0] COIN_MID    = 4'd2,
   parameter logic [3:0] COIN_LO     = 4'd1,
   parameter int         ACK_TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       vend_req,
   input  logic [3:0] paid,
   input  logic [3:0] price,
   input  logic       coin_ack,
   output logic       busy,
   output logic       cup_dispense,
   output logic       coin_valid,
   output logic [3:0] coin_value,
   output logic       LED_green,
   output logic       LED_yellow,
   output logic       jam
);

   localparam int WAIT_W = $clog2(ACK_TIMEOUT + 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CALC   = 3'd1,
      CUP    = 3'd2,
      CHANGE = 3'd3,
      DONE   = 3'd4,
      FAULT  = 3'd5
   } state_t;

   state_t              state, state_nx;
   logic [3:0]          paid_r, paid_nx;
   logic [3:0]          price_r, price_nx;
   logic [3:0]          remain, remain_nx;
   logic [WAIT_W-1:0]   wait_cnt, wait_nx;
   logic                sale, sale_nx;
   logic [3:0]          coin_sel;
   logic                offering;

   // Greedy pick: largest coin that still fits in the remaining change.
   always_comb begin
      coin_sel = COIN_LO;
      if (remain >= COIN_HI)
         coin_sel = COIN_HI;
      else if (remain >= COIN_MID)
         coin_sel = COIN_MID;
   end

   // A coin is on offer only while change is still owed.
   assign offering = (state == CHANGE) && (remain != 4'd0);

   // Outputs decode purely from registered state, so reset clears them at once.
   always_comb begin
      busy         = (state != IDLE);
      cup_dispense = (state == CUP);
      coin_valid   = offering;
      coin_value   = offering ? coin_sel : 4'd0;
      LED_green    = (state == DONE) && sale;
      LED_yellow   = (state == DONE) && !sale;
      jam          = (state == FAULT);
   end

   // Next-state and datapath updates; everything holds unless a state acts.
   always_comb begin
      state_nx  = state;
      paid_nx   = paid_r;
      price_nx  = price_r;
      remain_nx = remain;
      wait_nx   = wait_cnt;
      sale_nx   = sale;
      case (state)
         IDLE: begin
            if (vend_req) begin
               paid_nx  = paid;
               price_nx = price;
               state_nx = CALC;
            end
         end
         CALC: begin
            wait_nx = '0;
            if (paid_r >= price_r) begin
               remain_nx = paid_r - price_r;
               sale_nx   = 1'b1;
               state_nx  = CUP;
            end else begin
               remain_nx = paid_r;
               sale_nx   = 1'b0;
               state_nx  = CHANGE;
            end
         end
         CUP: begin
            state_nx = CHANGE;
         end
         CHANGE: begin
            if (remain == 4'd0) begin
               state_nx = DONE;
            end else if (coin_ack) begin
               remain_nx = remain - coin_sel;
               wait_nx   = '0;
            end else if (wait_cnt == WAIT_W'(ACK_TIMEOUT - 1)) begin
               // This unacknowledged cycle brings the wait up to the limit.
               state_nx = FAULT;
            end else begin
               wait_nx = wait_cnt + WAIT_W'(1);
            end
         end
         DONE: begin
            state_nx = IDLE;
         end
         FAULT: begin
            state_nx = FAULT;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // State and datapath registers with asynchronous active-low clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         paid_r   <= 4'd0;
         price_r  <= 4'd0;
         remain   <= 4'd0;
         wait_cnt <= '0;
         sale     <= 1'b0;
      end else begin
         state    <= state_nx;
         paid_r   <= paid_nx;
         price_r  <= price_nx;
         remain   <= remain_nx;
         wait_cnt <= wait_nx;
         sale     <= sale_nx;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_change_dispenser.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_change_dispenser
//  Description : Directed scoreboard bench for change_dispenser.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_change_dispenser;

   logic       clk      = 1'b0;
   logic       rst_n    = 1'b0;
   logic       vend_req = 1'b0;
   logic [3:0] paid     = 4'd0;
   logic [3:0] price    = 4'd0;
   logic       coin_ack = 1'b0;
   logic       busy, cup_dispense, coin_valid, LED_green, LED_yellow, jam;
   logic [3:0] coin_value;

   change_dispenser #(
      .COIN_HI(4'd5), .COIN_MID(4'd2), .COIN_LO(4'd1), .ACK_TIMEOUT(15)
   ) dut (
      .clk(clk), .rst_n(rst_n), .vend_req(vend_req), .paid(paid), .price(price),
      .coin_ack(coin_ack), .busy(busy), .cup_dispense(cup_dispense),
      .coin_valid(coin_valid), .coin_value(coin_value), .LED_green(LED_green),
      .LED_yellow(LED_yellow), .jam(jam)
   );

   always #5 clk = ~clk;

   localparam int K_CUP = 0, K_COIN = 1, K_GREEN = 2, K_YELLOW = 3, K_JAM = 4;

   typedef struct {
      int kind;
      int value;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   errors   = 0;
   int   cyc      = 0;
   int   ack_mode = 0;   // 0: low, 1: tied high, 2: ack after 3 wait cycles
   int   dly      = 0;

   // Cycle counter used to time the cup pulse.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic push(input int kind, input int value);
      exp_t e;
      e.kind  = kind;
      e.value = value;
      exp_q.push_back(e);
   endtask

   task automatic expect_evt(input int kind, input int value);
      exp_t e;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL unexpected_event: actual kind=%0d value=%0d required none", kind, value);
      end else begin
         e = exp_q.pop_front();
         check("event_kind", kind, e.kind);
         check("event_value", value, e.value);
      end
   endtask

   // Coin mechanism model.
   always @(posedge clk) begin
      #1;
      case (ack_mode)
         1: coin_ack = 1'b1;
         2: begin
            if (coin_ack) begin
               coin_ack = 1'b0;
               dly      = coin_valid ? 1 : 0;
            end else if (coin_valid) begin
               if (dly == 3) coin_ack = 1'b1;
               else          dly++;
            end else begin
               dly = 0;
            end
         end
         default: coin_ack = 1'b0;
      endcase
   end

   // Monitor: pops the scoreboard whenever the DUT presents an event.
   logic       prev_wait = 1'b0;
   logic [3:0] prev_val  = 4'd0;
   logic       jam_prev  = 1'b0;
   always @(negedge clk) begin
      if (rst_n) begin
         if (prev_wait && !jam) begin
            check("coin_held_valid", coin_valid, 1);
            check("coin_held_value", coin_value, prev_val);
         end
         if (!coin_valid && coin_value != 4'd0) check("coin_value_idle", coin_value, 0);
         if (cup_dispense)            expect_evt(K_CUP, cyc);
         if (coin_valid && coin_ack)  expect_evt(K_COIN, coin_value);
         if (LED_green)               expect_evt(K_GREEN, 0);
         if (LED_yellow)              expect_evt(K_YELLOW, 0);
         if (jam && !jam_prev)        expect_evt(K_JAM, 0);
         prev_wait = coin_valid && !coin_ack;
         prev_val  = coin_value;
         jam_prev  = jam;
      end else begin
         prev_wait = 1'b0;
         jam_prev  = 1'b0;
      end
   end

   task automatic check_all_zero(input string name);
      check({name, "_busy"},   busy, 0);
      check({name, "_cup"},    cup_dispense, 0);
      check({name, "_cvalid"}, coin_valid, 0);
      check({name, "_cvalue"}, coin_value, 0);
      check({name, "_green"},  LED_green, 0);
      check({name, "_yellow"}, LED_yellow, 0);
      check({name, "_jam"},    jam, 0);
   endtask

   // Issue one request and queue its hand-computed responses (coin 0 = none).
   task automatic vend(input int p, input int pr, input bit cup,
                       input int c0, input int c1, input int c2, input int c3,
                       input int led);
      @(posedge clk); #1;
      paid     = 4'(p);
      price    = 4'(pr);
      vend_req = 1'b1;
      if (cup)     push(K_CUP, cyc + 2);
      if (c0 != 0) push(K_COIN, c0);
      if (c1 != 0) push(K_COIN, c1);
      if (c2 != 0) push(K_COIN, c2);
      if (c3 != 0) push(K_COIN, c3);
      if (led >= 0) push(led, 0);
      @(posedge clk); #1;
      vend_req = 1'b0;
   endtask

   task automatic wait_settled(input string name);
      int n = 0;
      while ((busy || exp_q.size() != 0) && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      check({name, "_settled"}, (busy || exp_q.size() != 0) ? 1 : 0, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      int vcount;
      #1;
      check_all_zero("reset");
      repeat (3) @(posedge clk);

      // Release reset and request on the very first edge: 9 paid, 6 price.
      #1;
      rst_n    = 1'b1;
      ack_mode = 1;
      paid     = 4'd9;
      price    = 4'd6;
      vend_req = 1'b1;
      push(K_CUP, cyc + 2);
      push(K_COIN, 2);
      push(K_COIN, 1);
      push(K_GREEN, 0);
      @(posedge clk); #1;
      vend_req = 1'b0;
      wait_settled("sale_9_6");
      check("sale_9_6_busy_low", busy, 0);

      // Insufficient funds: full refund of 3, no cup.
      vend(3, 7, 1'b0, 2, 1, 0, 0, K_YELLOW);
      wait_settled("refund_3_7");

      // Slow coin mechanism: 13 change as 5,5,2,1; a stray request is ignored.
      ack_mode = 2;
      vend(15, 2, 1'b1, 5, 5, 2, 1, K_GREEN);
      repeat (4) @(posedge clk);
      #1;
      paid     = 4'd1;
      price    = 4'd9;
      vend_req = 1'b1;
      @(posedge clk); #1;
      vend_req = 1'b0;
      wait_settled("slow_15_2");

      // Exact payment and the all-zero sale: cup, no coins, green.
      ack_mode = 1;
      vend(4, 4, 1'b1, 0, 0, 0, 0, K_GREEN);
      wait_settled("exact_4_4");
      vend(0, 0, 1'b1, 0, 0, 0, 0, K_GREEN);
      wait_settled("zero_0_0");

      // Reset while the second coin (2) is on offer.
      ack_mode = 2;
      vend(8, 1, 1'b1, 5, 0, 0, 0, -1);
      n = 0;
      while (!(exp_q.size() == 0 && coin_valid && coin_value == 4'd2) && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check("second_coin_offered", (n < 100) ? 1 : 0, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("mid_reset");
      ack_mode = 0;
      coin_ack = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      check("after_reset_busy", busy, 0);
      ack_mode = 1;
      vend(9, 6, 1'b1, 2, 1, 0, 0, K_GREEN);
      wait_settled("after_reset_sale");

      // Coin never taken: jam after 15 offered cycles, sticky until reset.
      ack_mode = 0;
      vend(8, 1, 1'b1, 0, 0, 0, 0, K_JAM);
      vcount = 0;
      n = 0;
      while (!jam && n < 100) begin
         @(posedge clk); #1;
         if (coin_valid) vcount++;
         n++;
      end
      check("jam_timeout_cycles", vcount, 15);
      check("jam_set", jam, 1);
      check("jam_coin_dropped", coin_valid, 0);
      @(posedge clk); #1;
      paid     = 4'd9;
      price    = 4'd6;
      vend_req = 1'b1;
      @(posedge clk); #1;
      vend_req = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("jam_sticky", jam, 1);
      check("jam_busy", busy, 1);
      check("jam_queue_drained", exp_q.size(), 0);
      rst_n = 1'b0;
      #1;
      check_all_zero("jam_reset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("final_queue_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
